card_dealer_arb: RTL

// Sits between the free-running card generator (current_card, 1..11, new value every

---
 rtl/card_dealer_arb_if.sv | 26 ++
 rtl/card_dealer_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer_arb_if.sv
// Handshake bundle between the card dealer arbiter and the game logic.
// Signal directions are named from the dealer's side: i_* flow into the
// dealer, o_* flow out of it.
interface card_dealer_arb_if;
    logic [3:0] i_currentCard;
    logic       i_pReq;
    logic       i_dReq;
    logic       i_pAck;
    logic       i_dAck;
    logic [3:0] o_cardOut;
    logic       o_pValid;
    logic       o_dValid;
    logic [6:0] o_cardsLeft;
    logic       o_shoeEmpty;
    logic       o_busy;

    modport slave (
        input  i_currentCard, i_pReq, i_dReq, i_pAck, i_dAck,
        output o_cardOut, o_pValid, o_dValid, o_cardsLeft, o_shoeEmpty, o_busy
    );

    modport master (
        output i_currentCard, i_pReq, i_dReq, i_pAck, i_dAck,
        input  o_cardOut, o_pValid, o_dValid, o_cardsLeft, o_shoeEmpty, o_busy
    );
endinterface

// File: rtl/card_dealer_arb.sv
// Card dealer arbiter: shares the free-running card generator between the
// player and the dealer with round-robin priority, enforces a finite shoe
// (per-value copy limits) and hands each card over a valid/ack handshake.
// i_key[1] is the asynchronous active-low reset, i_key[0] the active-low
// new-shoe button.
module card_dealer_arb #(
    parameter int COPIES     = 4,
    parameter int TEN_COPIES = 16,
    parameter int RETRY_MAX  = 32
) (
    input  logic       i_clock50,
    input  logic [1:0] i_key,
    card_dealer_arb_if.slave bus
);

    localparam logic [6:0] FRESH_CARDS = 7'(10 * COPIES + TEN_COPIES);
    localparam logic [7:0] RETRY_LIMIT = 8'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_CHECK,
        S_SCAN,
        S_DELIVER
    } state_t;

    // Copy limit for a card value: tens have their own larger pool.
    function automatic logic [4:0] limitOf(input logic [3:0] value);
        return (value == 4'd10) ? 5'(TEN_COPIES) : 5'(COPIES);
    endfunction

    logic       w_rstAsyncN;
    logic       w_rstN;
    logic [1:0] r_rstSync;
    logic [1:0] r_keySync;
    logic       r_keyPrev;
    logic       w_newShoeEdge;

    state_t     r_state;
    logic       r_grantDealer;
    logic       r_rrDealer;
    logic [3:0] r_cand;
    logic [7:0] r_retry;
    logic [4:0] r_used [0:15];
    logic [6:0] r_cardsLeft;
    logic       r_shoeEmpty;
    logic       r_pending;
    logic [3:0] r_cardOut;
    logic       r_pValid;
    logic       r_dValid;
    logic       r_busy;

    logic       w_grantReq;
    logic       w_candOk;
    logic       w_candInRange;
    logic       w_ackMatch;
    logic [3:0] w_scanValue;
    logic       w_commit;
    logic [3:0] w_commitValue;

    assign w_rstAsyncN = i_key[1];
    assign w_rstN      = r_rstSync[1];

    // Reset asserts immediately but is released only after two clean clock edges.
    always_ff @(posedge i_clock50 or negedge w_rstAsyncN) begin
        if (!w_rstAsyncN) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end

    // Bring the new-shoe button into the clock domain and remember its last level.
    always_ff @(posedge i_clock50 or negedge w_rstN) begin
        if (!w_rstN) begin
            r_keySync <= 2'b11;
            r_keyPrev <= 1'b1;
        end else begin
            r_keySync <= {r_keySync[0], i_key[0]};
            r_keyPrev <= r_keySync[1];
        end
    end

    assign w_newShoeEdge = r_keyPrev & ~r_keySync[1];

    assign w_grantReq    = r_grantDealer ? bus.i_dReq : bus.i_pReq;
    assign w_ackMatch    = r_grantDealer ? bus.i_dAck : bus.i_pAck;
    assign w_candInRange = (bus.i_currentCard >= 4'd1) && (bus.i_currentCard <= 4'd11);
    assign w_candOk      = r_used[r_cand] < limitOf(r_cand);

    // Fallback choice: lowest card value that still has copies left in the shoe.
    always_comb begin
        w_scanValue = 4'd1;
        for (int v = 11; v >= 1; v--) begin
            if (r_used[v] < limitOf(4'(v))) begin
                w_scanValue = 4'(v);
            end
        end
    end

    assign w_commit      = ((r_state == S_CHECK) && w_grantReq && w_candOk) || (r_state == S_SCAN);
    assign w_commitValue = (r_state == S_SCAN) ? w_scanValue : r_cand;

    // Main controller: arbitration, sampling, shoe bookkeeping and delivery.
    always_ff @(posedge i_clock50 or negedge w_rstN) begin
        if (!w_rstN) begin
            r_state       <= S_IDLE;
            r_grantDealer <= 1'b0;
            r_rrDealer    <= 1'b0;
            r_cand        <= 4'd0;
            r_retry       <= 8'd0;
            for (int v = 0; v < 16; v++) begin
                r_used[v] <= 5'd0;
            end
            r_cardsLeft   <= FRESH_CARDS;
            r_shoeEmpty   <= 1'b0;
            r_pending     <= 1'b0;
            r_cardOut     <= 4'd0;
            r_pValid      <= 1'b0;
            r_dValid      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (w_newShoeEdge) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        for (int v = 0; v < 16; v++) begin
                            r_used[v] <= 5'd0;
                        end
                        r_cardsLeft <= FRESH_CARDS;
                        r_shoeEmpty <= 1'b0;
                        r_pending   <= w_newShoeEdge;
                    end else if (!r_shoeEmpty && (bus.i_pReq || bus.i_dReq)) begin
                        r_grantDealer <= bus.i_dReq && (!bus.i_pReq || r_rrDealer);
                        r_retry       <= 8'd0;
                        r_state       <= S_SAMPLE;
                        r_busy        <= 1'b1;
                    end
                end

                S_SAMPLE: begin
                    if (!w_grantReq) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_candInRange) begin
                        r_cand  <= bus.i_currentCard;
                        r_state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (!w_grantReq) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_candOk) begin
                        r_state <= S_DELIVER;
                    end else begin
                        r_retry <= r_retry + 8'd1;
                        if ((r_retry + 8'd1) == RETRY_LIMIT) begin
                            r_state <= S_SCAN;
                        end else begin
                            r_state <= S_SAMPLE;
                        end
                    end
                end

                S_SCAN: begin
                    r_state <= S_DELIVER;
                end

                S_DELIVER: begin
                    if (w_ackMatch) begin
                        r_pValid   <= 1'b0;
                        r_dValid   <= 1'b0;
                        r_rrDealer <= ~r_grantDealer;
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_commit) begin
                r_used[w_commitValue] <= r_used[w_commitValue] + 5'd1;
                if (r_cardsLeft != 7'd0) begin
                    r_cardsLeft <= r_cardsLeft - 7'd1;
                end
                r_shoeEmpty <= (r_cardsLeft <= 7'd1);
                r_cardOut   <= w_commitValue;
                r_pValid    <= ~r_grantDealer;
                r_dValid    <= r_grantDealer;
            end
        end
    end

    assign bus.o_cardOut   = r_cardOut;
    assign bus.o_pValid    = r_pValid;
    assign bus.o_dValid    = r_dValid;
    assign bus.o_cardsLeft = r_cardsLeft;
    assign bus.o_shoeEmpty = r_shoeEmpty;
    assign bus.o_busy      = r_busy;

endmodule
